// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit.
//   fetch_state_t   : fetch FSM state encoding
//   XLEN_DEF        : default datapath/address width
//   RESET_PC_DEF    : default fetch address after reset
//   TIMEOUT_CYC_DEF : default watchdog limit (cycles spent in REQ or WAIT)
//   PC_INC          : sequential fetch stride in bytes
package fetch_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;
  localparam int unsigned PC_INC          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/response channels.
//   imem_req_valid : request valid (fetch unit -> memory)
//   imem_req_ready : request accepted (memory -> fetch unit)
//   imem_req_addr  : request address, XLEN bits
//   imem_rsp_valid : response valid, always accepted by the fetch unit
//   imem_rsp_data  : response data, XLEN bits
// master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = fetch_pkg::XLEN_DEF
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_timeout.sv
// fetch_timeout: watchdog for the fetch FSM (only built with FETCH_TIMEOUT_EN).
//   clk     : clock
//   reset   : synchronous active-low reset
//   state   : current fetch FSM state
//   expired : high in the TIMEOUT_CYC-th consecutive cycle of the same
//             REQ or WAIT state, so the FSM leaves on that edge
// Down-counter reloaded whenever the FSM changes state.
module fetch_timeout
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  fetch_state_t state,
  output logic         expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  fetch_state_t  prev_state;
  logic [CW-1:0] remaining;
  logic          run;
  logic          entry;

  assign run   = (state == REQ) || (state == WAIT);
  assign entry = (state != prev_state);

  // On the entry cycle the counter still holds a stale value, so the
  // one-cycle limit is decided from the parameter directly.
  assign expired = run && (entry ? (TIMEOUT_CYC == 1) : (remaining == CW'(1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_state <= IDLE;
      remaining  <= '0;
    end else begin
      prev_state <= state;
      if (entry) begin
        remaining <= CW'(TIMEOUT_CYC - 1);
      end else if (run && (remaining != '0)) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch sequencer.
//   clk           : clock, all logic on posedge
//   reset         : synchronous active-low reset
//   en_fetch      : one-cycle fetch request
//   branch        : redirect strobe, highest priority
//   branch_target : redirect address (bits [1:0] dropped)
//   imem          : instruction-memory request/response (master modport)
//   instr         : last accepted instruction
//   pc            : current fetch address
//   fetch_done    : one-cycle completion pulse
//   busy          : fetch in progress (REQ, WAIT, DONE)
//   fetch_fault   : sticky watchdog flag, cleared by reset or branch
// Build option: define FETCH_TIMEOUT_EN to include the fetch_timeout
// watchdog; otherwise REQ/WAIT wait indefinitely and fetch_fault is 0.
//
// state | meaning
// IDLE  | waiting for en_fetch (or a latched pending fetch)
// REQ   | request presented at pc, waiting for ready
// WAIT  | request accepted, waiting for response
// DONE  | instr valid, fetch_done high, pc advances on exit
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
  parameter int unsigned     TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_fetch,
  input  logic                branch,
  input  logic [XLEN-1:0]     branch_target,
  instr_fetch_unit_if.master  imem,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     pc,
  output logic                fetch_done,
  output logic                busy,
  output logic                fetch_fault
);

  fetch_state_t state;
  logic         discard;
  logic         pending;
  logic         timeout_hit;
  logic         rsp_valid;

  assign rsp_valid = imem.imem_rsp_valid;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fetch_timeout (
    .clk     (clk),
    .reset   (reset),
    .state   (state),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      discard     <= 1'b0;
      pending     <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (branch) begin
      state       <= IDLE;
      pc          <= branch_target & ~XLEN'(3);
      pending     <= 1'b0;
      fetch_fault <= 1'b0;
      // A request already accepted by memory will still answer; remember
      // to swallow it. A response arriving right now is simply dropped.
      if (state == WAIT) begin
        discard <= !rsp_valid;
      end else if (rsp_valid) begin
        discard <= 1'b0;
      end
    end else begin
      if (discard && rsp_valid) begin
        discard <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!discard && (en_fetch || pending)) begin
            state   <= REQ;
            pending <= 1'b0;
          end else if (discard && en_fetch) begin
            pending <= 1'b1;
          end
        end
        REQ: begin
          if (imem.imem_req_ready) begin
            state <= WAIT;
          end else if (timeout_hit) begin
            state       <= IDLE;
            fetch_fault <= 1'b1;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            instr <= imem.imem_rsp_data;
            state <= DONE;
          end else if (timeout_hit) begin
            state       <= IDLE;
            fetch_fault <= 1'b1;
            discard     <= 1'b1;
          end
        end
        DONE: begin
          pc    <= pc + XLEN'(PC_INC);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pure decodes of the state register; no input reaches these outputs.
  assign busy                = (state != IDLE);
  assign fetch_done          = (state == DONE);
  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_req_addr  = pc;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath/address width; RESET_PC, default 32'h0000_0000, PC after reset; TIMEOUT_CYC, default 16, watchdog limit.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports: en_fetch  in  1  one-cycle fetch request from the processor sequencer.
REQ-005 SHALL have ports: branch  in  1  redirect strobe; branch_target  in  XLEN  redirect address.
REQ-006 SHALL have ports: imem_req_valid  out  1; imem_req_ready  in  1; imem_req_addr  out  XLEN  (instruction-memory request channel).
REQ-007 SHALL have ports: imem_rsp_valid  in  1; imem_rsp_data  in  XLEN  (response channel, always accepted).
REQ-008 SHALL have ports: instr  out  XLEN  latched instruction; pc  out  XLEN  current fetch address.
REQ-009 SHALL have ports: fetch_done  out  1  one-cycle completion pulse; busy  out  1  fetch in progress; fetch_fault  out  1  sticky timeout flag.

Function
REQ-010 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-011 IDLE: en_fetch=1 and no discard pending -> REQ; busy=0.
REQ-012 REQ: imem_req_valid=1, imem_req_addr=pc; handshake on valid&ready -> WAIT; otherwise hold request and address stable.
REQ-013 WAIT: imem_rsp_valid=1 -> instr<=imem_rsp_data, -> DONE.
REQ-014 DONE: fetch_done=1 for exactly one cycle, pc holds the fetched address; next cycle pc<=pc+4 (mod 2^XLEN, 32'hFFFF_FFFC wraps to 0), -> IDLE.
REQ-015 busy SHALL be 1 in REQ, WAIT, DONE.
REQ-016 Zero-wait latency: en_fetch at T, req handshake T+1, rsp at T+2, fetch_done and instr valid at T+3, pc+4 visible T+4.
REQ-017 en_fetch received while busy SHALL be ignored.
REQ-018 branch=1 in any state SHALL set pc<=branch_target with bits [1:0] forced to 0 and return to IDLE next cycle; fetch_done SHALL NOT pulse for the abandoned fetch.
REQ-019 branch has priority over en_fetch, handshake and response in the same cycle; a coincident en_fetch SHALL be dropped.
REQ-020 branch while in WAIT without a coincident rsp SHALL set discard flag; next imem_rsp_valid is consumed without updating instr, then flag clears.
REQ-021 en_fetch arriving while discard is pending SHALL be latched (one-deep) and serviced from IDLE once discard clears.
REQ-022 instr SHALL hold its value except on accepted, non-discarded responses.

Reset
REQ-023 On reset=0 at posedge: state IDLE, pc=RESET_PC, instr=0, discard and pending flags=0, fetch_fault=0, all strobes 0.
REQ-024 Reset mid-fetch SHALL abandon the transaction; an in-flight response after reset SHALL be ignored (discard flag NOT set; memory assumed reset concurrently).

Configuration
REQ-025 Macro FETCH_TIMEOUT_EN defined: counter runs in REQ/WAIT, clears on state entry; reaching TIMEOUT_CYC sets fetch_fault (sticky until reset or branch), returns to IDLE, sets discard if leaving WAIT.
REQ-026 FETCH_TIMEOUT_EN undefined: no counter, fetch_fault tied 0, REQ/WAIT wait indefinitely.

Structure
REQ-027 Package fetch_pkg SHALL hold the state enum, XLEN default, RESET_PC default, TIMEOUT_CYC default, PC increment constant 4.
REQ-028 Watchdog SHALL be sub-module fetch_timeout, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-029 Zero-wait: pc=0x100, en_fetch, ready=1, rsp 0x00500093 next cycle -> fetch_done at T+3, instr=0x00500093, pc=0x104 at T+4.
REQ-030 Backpressure: ready=0 for 3 cycles -> req_valid held, addr stable 0x104, single handshake, one fetch_done.
REQ-031 Branch in WAIT to 0x203 -> pc=0x200, no fetch_done, late rsp 0xDEADBEEF discarded (instr unchanged), next fetch at 0x200.
REQ-032 Branch and en_fetch same cycle in IDLE -> pc=target, no request issued, busy stays 0.
REQ-033 Wrap: pc=0xFFFF_FFFC fetch -> pc=0x0 after DONE; reset=0 mid-REQ -> pc=RESET_PC, req_valid=0 next cycle.
REQ-034 FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, ready=0 forever -> fetch_fault=1 after 16 REQ cycles, state IDLE, cleared by branch.
